// File: rtl/nibble_serial_adder_if.sv
// Request/result handshake bundle for nibble_serial_adder.
// Optional overflow flag present when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             out_ovf;
`endif

  // Upstream requester and downstream consumer side
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , input out_ovf
`endif
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_carry
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Nibble-serial add sequencer: feeds an external 4-bit full adder one nibble
// per cycle (LSN first), chains the carry in a register and assembles the
// WIDTH-bit sum. Optional signed overflow flag: NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  nibble_serial_adder_if.slave bus,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [3:0] add_sum,
  input  logic       add_carry,
  output logic       busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_nxt;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_carry_r;
  logic             busy_r;
  logic             run;
  logic             last;

  // Two's-complement overflow of the top nibble: like-signed inputs whose
  // sum flips sign.
  function automatic logic signed_ovf(input logic signed [3:0] a,
                                      input logic signed [3:0] b,
                                      input logic signed [3:0] s);
    return (a[3] == b[3]) && (s[3] != a[3]);
  endfunction

  assign run  = (state == RUN);
  assign last = (cnt == CNT_W'(NIBBLES - 1));

  // Adder operands come only from registers and are zero outside RUN
  assign add_a   = run ? op_a[3:0] : 4'd0;
  assign add_b   = run ? op_b[3:0] : 4'd0;
  assign add_cin = run ? carry     : 1'b0;

  // New sum nibble enters at the top; earlier nibbles move toward the LSB
  generate
    if (NIBBLES == 1) begin : g_single
      assign result_nxt = add_sum;
    end else begin : g_multi
      assign result_nxt = {add_sum, result[WIDTH-1:4]};
    end
  endgenerate

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_carry = out_carry_r;
  assign busy          = busy_r;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic out_ovf_r;
  assign bus.out_ovf = out_ovf_r;
`endif

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      carry       <= 1'b0;
      result      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_carry_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      out_ovf_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_a       <= bus.in_a;
            op_b       <= bus.in_b;
            carry      <= bus.in_cin;
            result     <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          result <= result_nxt;
          op_a   <= op_a >> 4;
          op_b   <= op_b >> 4;
          carry  <= add_carry;
          cnt    <= cnt + 1'b1;
          if (last) begin
            out_sum_r   <= result_nxt;
            out_carry_r <= add_carry;
            out_valid_r <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            out_ovf_r   <= signed_ovf(add_a, add_b, add_sum);
`endif
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a behavioural 4-bit adder and a
// result scoreboard.
module tb_nibble_serial_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_carry, busy;
  logic [4:0] add_full;

  int n_vec = 0;
  int n_err = 0;

  typedef logic [W+1:0] exp_t;  // {ovf, carry, sum}
  exp_t sb[$];

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .busy      (busy)
  );

  assign add_full  = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_sum   = add_full[3:0];
  assign add_carry = add_full[4];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow the nibble sequence and check the result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] full;
    logic       ovf;
    logic       c;
    logic [4:0] ns;
    logic [3:0] an, bn;
    exp_t       e;
    int         k;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    sb.push_back({ovf, full});
    c = cin;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k <= 20) begin
      if (k <= NIB) begin
        an = 4'((a >> (4 * (k - 1))) & 'hF);
        bn = 4'((b >> (4 * (k - 1))) & 'hF);
        check("add_a_seq", 32'(add_a), 32'(an));
        check("add_cin_seq", 32'(add_cin), 32'(c));
        ns = {1'b0, an} + {1'b0, bn} + {4'd0, c};
        c  = ns[4];
      end
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(NIB + 1));
    if (bus.out_valid) begin
      e = sb.pop_front();
      check("out_sum", 32'(bus.out_sum), 32'(e[W-1:0]));
      check("out_carry", 32'(bus.out_carry), 32'(e[W]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check("out_ovf", 32'(bus.out_ovf), 32'(e[W+1]));
`endif
    end
  endtask

  // After the transfer edge: valid gone, ready back, sum retained
  task automatic after_xfer(input logic [W-1:0] exp_sum);
    @(negedge clk);
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_ready", 32'(bus.in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_sum_hold", 32'(bus.out_sum), 32'(exp_sum));
  endtask

  initial begin
    logic [W-1:0] held;
    logic         seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_carry", 32'(bus.out_carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic adds with out_ready already high: single-cycle out_valid pulse
    run_op(16'h1234, 16'h1111, 1'b0);
    after_xfer(16'h2345);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    after_xfer(16'h0000);
    run_op(16'h00FF, 16'h0000, 1'b1);
    after_xfer(16'h0100);

    // Backpressure with a competing request while DONE
    bus.out_ready = 1'b0;
    run_op(16'hABCD, 16'h1357, 1'b1);
    held = bus.out_sum;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = i[0];
      bus.in_a     = 16'h5555;
      bus.in_b     = 16'h2222;
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_ready", 32'(bus.in_ready), 32'd0);
      check("bp_sum", 32'(bus.out_sum), 32'(held));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    after_xfer(held);

    // Overflow cases
    run_op(16'h7FFF, 16'h0001, 1'b0);
    after_xfer(16'h8000);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    after_xfer(16'h0000);
    run_op(16'h8000, 16'h8000, 1'b0);
    after_xfer(16'h0000);
    run_op(16'h4321, 16'h8765, 1'b1);
    after_xfer(16'hCA87);

    // Abort in the second RUN cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0F0F;
    bus.in_b     = 16'h0101;
    bus.in_cin   = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_sum", 32'(bus.out_sum), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_add", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid | busy;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    // Block still usable after the abort
    run_op(16'h0F0F, 16'h0101, 1'b0);
    after_xfer(16'h1010);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
